// File: rtl/mips_cpu_regfile_ctrl_pkg.sv
// Shared types and constants for the register-file write-port controller.
// Requester indices fix the writeback priority slots: ALU, load return, link.
package mips_cpu_ctrl_pkg;

    typedef logic [4:0] regaddr_t;

    localparam int       REQ_ALU  = 0;
    localparam int       REQ_LOAD = 1;
    localparam int       REQ_LINK = 2;
    localparam regaddr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/mips_cpu_regfile_ctrl_if.sv
// Bundle of issue, read-hazard, writeback-request and register-file write signals.
// The master side belongs to the pipeline; the slave side is the controller.
interface mips_cpu_regfile_ctrl_if
    import mips_cpu_ctrl_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = 32
);

    logic              issue_valid;
    regaddr_t          issue_dest;
    logic              issue_ready;
    regaddr_t          rdAddrA;
    regaddr_t          rdAddrB;
    logic              stallA;
    logic              stallB;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*5-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              write;
    regaddr_t          wrAddr;
    logic [DW-1:0]     wrData;
    logic [31:0]       busy_vec;

    modport master (
        output issue_valid, issue_dest, rdAddrA, rdAddrB,
               req_valid, req_addr, req_data,
        input  issue_ready, stallA, stallB, req_ready,
               write, wrAddr, wrData, busy_vec
    );

    modport slave (
        input  issue_valid, issue_dest, rdAddrA, rdAddrB,
               req_valid, req_addr, req_data,
        output issue_ready, stallA, stallB, req_ready,
               write, wrAddr, wrData, busy_vec
    );

endinterface

// File: rtl/mips_cpu_regfile_ctrl_arbiter.sv
// Combinational round-robin arbiter: searches from the requester after `last`
// and grants the first valid one, so every requester waits at most NREQ-1 grants.
module mips_cpu_rr_arbiter #(
    parameter int NREQ = 3,
    parameter int LW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   last,
    output logic [NREQ-1:0] grant
);

    logic          found;
    logic [LW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = LW'((int'(last) + k) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_cpu_regfile_ctrl.sv
// Register-file write-port controller: round-robin writeback arbitration,
// a registered write port, and a busy scoreboard that drives decode stalls.
module mips_cpu_regfile_ctrl
    import mips_cpu_ctrl_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    mips_cpu_regfile_ctrl_if.slave   bus
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [LW-1:0]   last;
    logic [NREQ-1:0] arbGrant;
    logic [NREQ-1:0] grant;
    logic            anyGrant;
    logic [LW-1:0]   grantIdx;
    regaddr_t        grantAddr;
    logic [DW-1:0]   grantData;
    logic [31:0]     busy;
    logic [31:0]     busyNext;
    logic            write;
    regaddr_t        wrAddr;
    logic [DW-1:0]   wrData;
    logic            issueReady;

    mips_cpu_rr_arbiter #(
        .NREQ (NREQ),
        .LW   (LW)
    ) u_arb (
        .req   (bus.req_valid),
        .last  (last),
        .grant (arbGrant)
    );

    assign grant    = reset ? '0 : arbGrant;
    assign anyGrant = |grant;

    always_comb begin
        grantIdx  = '0;
        grantAddr = REG_ZERO;
        grantData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grantIdx  = LW'(i);
                grantAddr = bus.req_addr[5*i +: 5];
                grantData = bus.req_data[DW*i +: DW];
            end
        end
    end

    // A busy register cannot be re-issued, even while its write is in flight;
    // this is what keeps a same-cycle clear and set from losing the new set.
    assign issueReady = !reset && !(busy[bus.issue_dest] && bus.issue_dest != REG_ZERO);

    always_comb begin
        busyNext = busy;
        if (write) begin
            busyNext[wrAddr] = 1'b0;
        end
        if (bus.issue_valid && issueReady && bus.issue_dest != REG_ZERO) begin
            busyNext[bus.issue_dest] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= '0;
            last   <= LW'(NREQ - 1);
            write  <= 1'b0;
            wrAddr <= REG_ZERO;
            wrData <= '0;
        end else begin
            busy  <= busyNext;
            write <= 1'b0;
            if (anyGrant) begin
                last   <= grantIdx;
                write  <= (grantAddr != REG_ZERO);
                wrAddr <= grantAddr;
                wrData <= grantData;
            end
        end
    end

    assign bus.issue_ready = issueReady;
    assign bus.stallA      = !reset && bus.rdAddrA != REG_ZERO && busy[bus.rdAddrA];
    assign bus.stallB      = !reset && bus.rdAddrB != REG_ZERO && busy[bus.rdAddrB];
    assign bus.req_ready   = grant;
    assign bus.write       = write;
    assign bus.wrAddr      = wrAddr;
    assign bus.wrData      = wrData;
    assign bus.busy_vec    = busy;

endmodule

// File: tb/tb_mips_cpu_regfile_ctrl.sv
// Directed bench for the register-file write-port controller.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mips_cpu_regfile_ctrl;
    import mips_cpu_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    mips_cpu_regfile_ctrl_if #(.NREQ(3), .DW(32)) bus ();

    mips_cpu_regfile_ctrl #(.NREQ(3), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idleInputs();
        bus.issue_valid = 1'b0;
        bus.issue_dest  = 5'd0;
        bus.rdAddrA     = 5'd0;
        bus.rdAddrB     = 5'd0;
        bus.req_valid   = 3'b000;
        bus.req_addr    = '0;
        bus.req_data    = '0;
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid   = 3'b111;
        bus.req_addr    = {5'd3, 5'd2, 5'd1};
        bus.issue_valid = 1'b1;
        bus.issue_dest  = 5'd4;
        bus.rdAddrA     = 5'd4;
        for (int c = 0; c < 2; c++) begin
            nextCycle();
            total++; if (bus.req_ready !== 3'b000) $display("[TB] FAIL reset_req_ready: got %b want 000", bus.req_ready); else passed++;
            total++; if (bus.write !== 1'b0) $display("[TB] FAIL reset_write: got %b want 0", bus.write); else passed++;
            total++; if (bus.busy_vec !== 32'h0) $display("[TB] FAIL reset_busy: got %h want 0", bus.busy_vec); else passed++;
        end
        total++; if (bus.issue_ready !== 1'b0) $display("[TB] FAIL reset_issue_ready: got %b want 0", bus.issue_ready); else passed++;
        total++; if (bus.stallA !== 1'b0) $display("[TB] FAIL reset_stallA: got %b want 0", bus.stallA); else passed++;
        total++; if (bus.wrAddr !== 5'd0 || bus.wrData !== 32'h0) $display("[TB] FAIL reset_wr: got %0d/%h want 0/0", bus.wrAddr, bus.wrData); else passed++;
        @(negedge clk);
        reset = 1'b0;
        idleInputs();
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.issue_dest  = 5'd5;
        bus.rdAddrA     = 5'd5;
        #1;
        total++; if (bus.issue_ready !== 1'b1) $display("[TB] FAIL single_issue_ready: got %b want 1", bus.issue_ready); else passed++;
        total++; if (bus.stallA !== 1'b0) $display("[TB] FAIL single_stall_early: got %b want 0", bus.stallA); else passed++;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.req_valid   = 3'b001;
        bus.req_addr    = {5'd0, 5'd0, 5'd5};
        bus.req_data    = {32'h0, 32'h0, 32'hDEADBEEF};
        #1;
        total++; if (bus.stallA !== 1'b1) $display("[TB] FAIL single_stall_set: got %b want 1", bus.stallA); else passed++;
        total++; if (bus.busy_vec !== 32'h0000_0020) $display("[TB] FAIL single_busy: got %h want 00000020", bus.busy_vec); else passed++;
        total++; if (bus.req_ready !== 3'b001) $display("[TB] FAIL single_grant: got %b want 001", bus.req_ready); else passed++;
        @(negedge clk);
        bus.req_valid = 3'b000;
        #1;
        total++; if (bus.write !== 1'b1 || bus.wrAddr !== 5'd5 || bus.wrData !== 32'hDEADBEEF)
            $display("[TB] FAIL single_write: got %b/%0d/%h want 1/5/deadbeef", bus.write, bus.wrAddr, bus.wrData); else passed++;
        total++; if (bus.stallA !== 1'b1) $display("[TB] FAIL single_stall_hold: got %b want 1", bus.stallA); else passed++;
        nextCycle();
        total++; if (bus.write !== 1'b0) $display("[TB] FAIL single_write_drop: got %b want 0", bus.write); else passed++;
        total++; if (bus.stallA !== 1'b0 || bus.busy_vec !== 32'h0) $display("[TB] FAIL single_stall_clear: got %b/%h want 0/0", bus.stallA, bus.busy_vec); else passed++;
        idleInputs();
    endtask

    task automatic test_round_robin();
        logic [2:0] expGrant;
        logic [4:0] expAddr;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_addr  = {5'd3, 5'd2, 5'd1};
        bus.req_data  = {32'hC2, 32'hB1, 32'hA0};
        #1;
        for (int c = 0; c < 6; c++) begin
            expGrant = 3'b001 << (c % 3);
            total++; if (bus.req_ready !== expGrant) $display("[TB] FAIL rr_grant_%0d: got %b want %b", c, bus.req_ready, expGrant); else passed++;
            if (c > 0) begin
                expAddr = 5'((c - 1) % 3 + 1);
                total++; if (bus.write !== 1'b1 || bus.wrAddr !== expAddr)
                    $display("[TB] FAIL rr_write_%0d: got %b/%0d want 1/%0d", c, bus.write, bus.wrAddr, expAddr); else passed++;
            end
            nextCycle();
        end
        bus.req_valid = 3'b000;
        #1;
        total++; if (bus.write !== 1'b1 || bus.wrAddr !== 5'd3 || bus.wrData !== 32'hC2)
            $display("[TB] FAIL rr_last_write: got %b/%0d/%h want 1/3/c2", bus.write, bus.wrAddr, bus.wrData); else passed++;
        idleInputs();
    endtask

    task automatic test_reg_zero();
        @(negedge clk);
        bus.req_valid = 3'b010;
        bus.req_addr  = {5'd0, 5'd0, 5'd0};
        bus.req_data  = {32'h0, 32'h1234, 32'h0};
        #1;
        total++; if (bus.req_ready !== 3'b010) $display("[TB] FAIL zero_grant: got %b want 010", bus.req_ready); else passed++;
        @(negedge clk);
        bus.req_valid   = 3'b000;
        bus.issue_valid = 1'b1;
        bus.issue_dest  = 5'd0;
        bus.rdAddrA     = 5'd0;
        #1;
        total++; if (bus.write !== 1'b0 || bus.wrAddr !== 5'd0 || bus.wrData !== 32'h1234)
            $display("[TB] FAIL zero_write: got %b/%0d/%h want 0/0/1234", bus.write, bus.wrAddr, bus.wrData); else passed++;
        total++; if (bus.issue_ready !== 1'b1) $display("[TB] FAIL zero_issue_ready: got %b want 1", bus.issue_ready); else passed++;
        total++; if (bus.stallA !== 1'b0) $display("[TB] FAIL zero_stall: got %b want 0", bus.stallA); else passed++;
        nextCycle();
        total++; if (bus.busy_vec !== 32'h0) $display("[TB] FAIL zero_busy: got %h want 0", bus.busy_vec); else passed++;
        idleInputs();
    endtask

    task automatic test_collision();
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.issue_dest  = 5'd7;
        bus.rdAddrA     = 5'd7;
        @(negedge clk);
        bus.req_valid = 3'b001;
        bus.req_addr  = {5'd0, 5'd0, 5'd7};
        bus.req_data  = {32'h0, 32'h0, 32'h77};
        #1;
        total++; if (bus.req_ready !== 3'b001) $display("[TB] FAIL coll_grant: got %b want 001", bus.req_ready); else passed++;
        total++; if (bus.issue_ready !== 1'b0) $display("[TB] FAIL coll_busy_reject: got %b want 0", bus.issue_ready); else passed++;
        @(negedge clk);
        bus.req_valid = 3'b000;
        #1;
        total++; if (bus.write !== 1'b1 || bus.wrAddr !== 5'd7) $display("[TB] FAIL coll_write: got %b/%0d want 1/7", bus.write, bus.wrAddr); else passed++;
        total++; if (bus.issue_ready !== 1'b0) $display("[TB] FAIL coll_same_cycle: got %b want 0", bus.issue_ready); else passed++;
        nextCycle();
        total++; if (bus.issue_ready !== 1'b1) $display("[TB] FAIL coll_next_cycle: got %b want 1", bus.issue_ready); else passed++;
        total++; if (bus.busy_vec !== 32'h0) $display("[TB] FAIL coll_cleared: got %h want 0", bus.busy_vec); else passed++;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        #1;
        total++; if (bus.busy_vec !== 32'h0000_0080 || bus.stallA !== 1'b1)
            $display("[TB] FAIL coll_reset_busy: got %h/%b want 00000080/1", bus.busy_vec, bus.stallA); else passed++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.issue_dest  = 5'd9;
        bus.rdAddrA     = 5'd9;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.req_valid   = 3'b100;
        bus.req_addr    = {5'd9, 5'd0, 5'd0};
        bus.req_data    = {32'h99, 32'h0, 32'h0};
        #1;
        total++; if (bus.busy_vec !== 32'h0000_0280) $display("[TB] FAIL mid_busy_before: got %h want 00000280", bus.busy_vec); else passed++;
        total++; if (bus.req_ready !== 3'b100) $display("[TB] FAIL mid_grant: got %b want 100", bus.req_ready); else passed++;
        @(negedge clk);
        reset         = 1'b1;
        bus.req_valid = 3'b111;
        bus.req_addr  = {5'd3, 5'd2, 5'd1};
        #1;
        total++; if (bus.req_ready !== 3'b000 || bus.stallA !== 1'b0)
            $display("[TB] FAIL mid_reset_comb: got %b/%b want 000/0", bus.req_ready, bus.stallA); else passed++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (bus.write !== 1'b0 || bus.busy_vec !== 32'h0 || bus.wrAddr !== 5'd0)
            $display("[TB] FAIL mid_reset_state: got %b/%h/%0d want 0/0/0", bus.write, bus.busy_vec, bus.wrAddr); else passed++;
        total++; if (bus.req_ready !== 3'b001) $display("[TB] FAIL mid_first_grant: got %b want 001", bus.req_ready); else passed++;
        @(negedge clk);
        idleInputs();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        idleInputs();
        test_reset();
        test_single();
        test_round_robin();
        test_reg_zero();
        test_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mips_cpu_regfile_ctrl.md
# mips_cpu_regfile_ctrl

Write-port controller and scoreboard for the 32x32 CPU register file. Arbitrates the single register-file write port between several writeback requesters (ALU, load return, link) with round-robin fairness. Tracks which registers have an outstanding write and raises read-hazard stalls for the decode stage. Sits between the execute/memory stages and the register file, driving its `write`/`wrAddr`/`wrData` inputs.

## Interface
- `NREQ`, 3: number of writeback requesters; index 0 = ALU, 1 = LOAD, 2 = LINK.
- `DW`, 32: data width.
- `clk` in 1: the only clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `issue_valid` in 1: decode issues an instruction with a destination register.
- `issue_dest` in 5: destination register of the issuing instruction.
- `issue_ready` out 1: issue accepted this cycle; combinational.
- `rdAddrA`, `rdAddrB` in 5 each: source registers being read by decode.
- `stallA`, `stallB` out 1 each: source has an outstanding write; combinational.
- `req_valid` in NREQ: writeback request per requester.
- `req_addr` in NREQ*5: packed destination per requester; requester i at bits [5i+4:5i].
- `req_data` in NREQ*DW: packed data per requester.
- `req_ready` out NREQ: one-hot grant; combinational.
- `write` out 1: register-file write enable; registered.
- `wrAddr` out 5: register-file write address; registered.
- `wrData` out DW: register-file write data; registered.
- `busy_vec` out 32: scoreboard state, for debug and the testbench.

## Operation
- **Scoreboard.** `busy[31:0]` holds one bit per register. Bit 0 is permanently 0.
- **Issue.**
  - `issue_ready = !reset && !(busy[issue_dest] && issue_dest!=0)`.
  - On `issue_valid && issue_ready` with `issue_dest != 0`, set `busy[issue_dest]`.
  - `issue_dest == 0` is always accepted and sets nothing.
- **Stalls.** `stallX = !reset && rdAddrX != 0 && busy[rdAddrX]`.
- **Arbitration.**
  - Round-robin pointer `last` (2 bits) holds the index of the most recent grant.
  - Search order is `last+1, last+2, …` modulo NREQ.
  - At most one `req_ready` bit is high, and only for a requester with `req_valid` high.
  - On a grant, `last` updates to the granted index. With no valid requests, `last` holds.
  - `req_ready` is 0 for all requesters during reset.
- **Writeback register.** On a grant to requester g:
  - If `req_addr[g] != 0`: next cycle `write=1`, `wrAddr=req_addr[g]`, `wrData=req_data[g]`.
  - If `req_addr[g] == 0`: the request is consumed, but `write=0` next cycle, and `wrAddr`/`wrData` still load.
  - With no grant, `write=0` next cycle; `wrAddr`/`wrData` hold.
- **Busy clear.** Bit `wrAddr` clears on the edge where `write` is 1, i.e. when the register file captures the data.
  - A write to a non-busy register is legal; the clear is a no-op.
- **Simultaneous clear and set, same register.** `issue_ready` sees busy=1, so the issue is rejected that cycle and accepted the next cycle. No lost update.
- **Simultaneous clear and set, different registers.** Both take effect.
- **Reset** (any cycle, including mid-request):
  - Clears `busy`, `write`, `wrAddr`, `wrData`.
  - Sets `last = NREQ-1`, so requester 0 is first after reset.
  - A pending registered write is discarded.

## Timing
- Reset values: `write=0`, `wrAddr=0`, `wrData=0`, `busy_vec=0`, `req_ready=0`, `issue_ready=0`, `stallA=stallB=0`.
- Grant in cycle N. `write` is high in cycle N+1, and the register file writes at the end of N+1.
- Busy clears at the end of N+1, so `stall` drops in N+2. The register file's combinational read then returns the new value: 2-cycle grant-to-use.
- Issue at cycle N: busy is set at the end of N, and `stall` rises in N+1.
- Throughput: one write per cycle sustained. A requester waits at most NREQ-1 cycles while asserted.

## Structure
- Package `mips_cpu_ctrl_pkg`:
  - `REQ_ALU=0`, `REQ_LOAD=1`, `REQ_LINK=2`.
  - `REG_ZERO=5'd0`.
  - typedef `regaddr_t` (logic [4:0]).
- Sub-module `mips_cpu_rr_arbiter`: parameterized NREQ, with inputs `req` and `last`, output one-hot `grant`, purely combinational. The controller owns the `last` register.

## Test plan
- **Reset:** assert `reset` 2 cycles with all `req_valid=3'b111` → `req_ready=0`, `write=0`, `busy_vec=0` throughout.
- **Single request:** issue dest 5. Next cycle `stallA=1` for `rdAddrA=5`. ALU requests addr 5, data 0xDEADBEEF → `req_ready=3'b001`, next cycle `write=1`, `wrAddr=5`, `wrData=0xDEADBEEF`, then `stallA=0` one cycle later.
- **Round-robin:** all three requesters valid continuously after reset → grant order 0,1,2,0,1,2; `write` high every cycle.
- **Register 0:** LOAD requests addr 0, data 0x1234 → `req_ready[1]=1`, `write` stays 0. Issue dest 0 → `issue_ready=1`, `busy_vec` unchanged, `stallA=0` for `rdAddrA=0`.
- **Same-register collision:** reg 7 busy and its writeback in flight (`write=1`, `wrAddr=7`) while issuing dest 7 → `issue_ready=0` that cycle, 1 the next, and `busy[7]` set again.
- **Reset mid-operation:** `reset` asserted in the cycle after a grant with busy[9]=1 → `write=0` next cycle, `busy_vec=0`, and the first grant after release goes to requester 0.
